// File: rtl/sakebi_ethernet_frame_rx_filt.sv
// Ethernet II receive parser: strips the header (optional 802.1Q tag), filters on
// destination MAC / EtherType and forwards the payload with full backpressure.
module sakebi_ethernet_frame_rx_filt #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned MAC_ADDR_WIDTH  = 48,
    parameter int unsigned ETHERTYPE_WIDTH = 16,
    parameter bit          VLAN_EN         = 1'b1,
    parameter bit          BCAST_EN        = 1'b1
) (
    input  logic                       i_axis_ACLK,
    input  logic                       i_axis_ARESETn,
    input  logic                       i_axis_TVALID,
    output logic                       o_axis_TREADY,
    input  logic [DATA_WIDTH-1:0]      i_axis_TDATA,
    input  logic                       i_axis_TLAST,
    output logic                       o_axis_TVALID,
    input  logic                       i_axis_TREADY,
    output logic [DATA_WIDTH-1:0]      o_axis_TDATA,
    output logic                       o_axis_TLAST,
    output logic [MAC_ADDR_WIDTH-1:0]  o_dst_mac_addr,
    output logic [MAC_ADDR_WIDTH-1:0]  o_src_mac_addr,
    output logic [ETHERTYPE_WIDTH-1:0] o_ethertype,
    output logic                       o_vlan_present,
    output logic [15:0]                o_vlan_tci,
    output logic                       o_hdr_valid,
    output logic                       o_frame_drop,
    output logic                       o_frame_runt,
    input  logic                       i_specify_mac_en,
    input  logic [MAC_ADDR_WIDTH-1:0]  i_mac_addr,
    input  logic                       i_specify_ethertype_en,
    input  logic [ETHERTYPE_WIDTH-1:0] i_ethertype
);

    localparam int unsigned CNT_W     = 3;
    localparam int unsigned TCI_WIDTH = 16;
    localparam logic [CNT_W-1:0] DST_LAST = CNT_W'(4);
    localparam logic [CNT_W-1:0] SRC_LAST = CNT_W'(5);
    localparam logic [CNT_W-1:0] TWO_LAST = CNT_W'(1);
    localparam logic [ETHERTYPE_WIDTH-1:0] TPID = ETHERTYPE_WIDTH'(16'h8100);

    typedef enum logic [2:0] {
        S_IDLE, S_DST, S_SRC, S_TYPE, S_TCI, S_ITYPE, S_PAYLOAD, S_DROP
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [MAC_ADDR_WIDTH-1:0]  dst_q, src_q;
    logic [ETHERTYPE_WIDTH-1:0] type_q;
    logic [TCI_WIDTH-1:0]       tci_q;
    logic                       vlan_q;

    logic                       rx_acc;
    logic [ETHERTYPE_WIDTH-1:0] type_full;
    logic                       mac_ok, type_ok, pass;
    logic                       decide, runt;

    assign rx_acc    = i_axis_TVALID && o_axis_TREADY;
    assign type_full = {type_q[ETHERTYPE_WIDTH-DATA_WIDTH-1:0], i_axis_TDATA};

    // Filter sees the EtherType byte being accepted this cycle
    assign mac_ok  = !i_specify_mac_en || (dst_q == i_mac_addr) ||
                     (BCAST_EN && (dst_q == {MAC_ADDR_WIDTH{1'b1}}));
    assign type_ok = !i_specify_ethertype_en || (type_full == i_ethertype);
    assign pass    = mac_ok && type_ok;

    assign o_axis_TREADY = (state_q == S_PAYLOAD) ? (!o_axis_TVALID || i_axis_TREADY) : 1'b1;

    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        decide  = 1'b0;
        runt    = 1'b0;
        if (rx_acc) begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (i_axis_TLAST) runt = 1'b1;
                    else              state_d = S_DST;
                end
                S_DST, S_SRC, S_TYPE, S_TCI, S_ITYPE: begin
                    if (i_axis_TLAST) begin
                        runt    = 1'b1;
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (state_q == S_DST && cnt_q == DST_LAST) begin
                        state_d = S_SRC;
                        cnt_d   = '0;
                    end else if (state_q == S_SRC && cnt_q == SRC_LAST) begin
                        state_d = S_TYPE;
                        cnt_d   = '0;
                    end else if (state_q == S_TCI && cnt_q == TWO_LAST) begin
                        state_d = S_ITYPE;
                        cnt_d   = '0;
                    end else if ((state_q == S_TYPE || state_q == S_ITYPE) && cnt_q == TWO_LAST) begin
                        cnt_d = '0;
                        if (state_q == S_TYPE && VLAN_EN && type_full == TPID) begin
                            state_d = S_TCI;
                        end else begin
                            decide  = 1'b1;
                            state_d = pass ? S_PAYLOAD : S_DROP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_PAYLOAD, S_DROP: begin
                    if (i_axis_TLAST) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Working header registers, shifted in MSB first
    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            dst_q  <= '0;
            src_q  <= '0;
            type_q <= '0;
            tci_q  <= '0;
            vlan_q <= 1'b0;
        end else if (rx_acc) begin
            case (state_q)
                S_IDLE: begin
                    dst_q  <= MAC_ADDR_WIDTH'(i_axis_TDATA);
                    tci_q  <= '0;
                    vlan_q <= 1'b0;
                end
                S_DST:           dst_q  <= {dst_q[MAC_ADDR_WIDTH-DATA_WIDTH-1:0], i_axis_TDATA};
                S_SRC:           src_q  <= {src_q[MAC_ADDR_WIDTH-DATA_WIDTH-1:0], i_axis_TDATA};
                S_TYPE, S_ITYPE: type_q <= type_full;
                S_TCI: begin
                    tci_q  <= {tci_q[TCI_WIDTH-DATA_WIDTH-1:0], i_axis_TDATA};
                    vlan_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output beat register, published header and status pulses
    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            o_axis_TVALID  <= 1'b0;
            o_axis_TDATA   <= '0;
            o_axis_TLAST   <= 1'b0;
            o_dst_mac_addr <= '0;
            o_src_mac_addr <= '0;
            o_ethertype    <= '0;
            o_vlan_present <= 1'b0;
            o_vlan_tci     <= '0;
            o_hdr_valid    <= 1'b0;
            o_frame_drop   <= 1'b0;
            o_frame_runt   <= 1'b0;
        end else begin
            o_frame_drop <= decide && !pass;
            o_frame_runt <= runt;

            if (state_q == S_PAYLOAD && rx_acc) begin
                o_axis_TVALID <= 1'b1;
                o_axis_TDATA  <= i_axis_TDATA;
                o_axis_TLAST  <= i_axis_TLAST;
            end else if (i_axis_TREADY) begin
                o_axis_TVALID <= 1'b0;
            end

            // A new pass wins over the previous frame's final handshake
            if (decide && pass) begin
                o_dst_mac_addr <= dst_q;
                o_src_mac_addr <= src_q;
                o_ethertype    <= type_full;
                o_vlan_present <= vlan_q;
                o_vlan_tci     <= tci_q;
                o_hdr_valid    <= 1'b1;
            end else if (o_axis_TVALID && i_axis_TREADY && o_axis_TLAST) begin
                o_hdr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sakebi_ethernet_frame_rx_filt.sv
// Directed bench with a payload scoreboard for the Ethernet RX parser/filter.
module tb_sakebi_ethernet_frame_rx_filt;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid, rx_last, tx_ready;
    logic [7:0]  rx_data;
    logic        o_tready, o_valid, o_last;
    logic [7:0]  o_data;
    logic [47:0] o_dst, o_src;
    logic [15:0] o_type, o_tci;
    logic        o_vlan, o_hdrv, o_drop, o_runt;
    logic        mac_en, type_en;
    logic [47:0] mac_addr;
    logic [15:0] ethertype;

    int checks = 0;
    int passed = 0;
    int drop_cnt = 0;
    int runt_cnt = 0;

    logic [8:0]  sb[$];
    logic [7:0]  frame_q[$];
    int          hdr_len;
    logic [47:0] exp_dst, exp_src;
    logic [15:0] exp_type, exp_tci;
    logic        exp_vlan;
    logic        held;
    logic [8:0]  held_beat;

    always #5 clk = ~clk;

    sakebi_ethernet_frame_rx_filt dut (
        .i_axis_ACLK(clk), .i_axis_ARESETn(rst_n),
        .i_axis_TVALID(rx_valid), .o_axis_TREADY(o_tready),
        .i_axis_TDATA(rx_data), .i_axis_TLAST(rx_last),
        .o_axis_TVALID(o_valid), .i_axis_TREADY(tx_ready),
        .o_axis_TDATA(o_data), .o_axis_TLAST(o_last),
        .o_dst_mac_addr(o_dst), .o_src_mac_addr(o_src),
        .o_ethertype(o_type), .o_vlan_present(o_vlan), .o_vlan_tci(o_tci),
        .o_hdr_valid(o_hdrv), .o_frame_drop(o_drop), .o_frame_runt(o_runt),
        .i_specify_mac_en(mac_en), .i_mac_addr(mac_addr),
        .i_specify_ethertype_en(type_en), .i_ethertype(ethertype)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard pop, hold stability, pulse counting
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (o_drop) drop_cnt = drop_cnt + 1;
            if (o_runt) runt_cnt = runt_cnt + 1;
            if (o_valid && !tx_ready) begin
                if (held) chk("hold_stable", {o_last, o_data}, held_beat);
                held = 1'b1;
                held_beat = {o_last, o_data};
            end else begin
                held = 1'b0;
            end
            if (o_valid && tx_ready) begin
                if (sb.size() == 0) chk("unexpected_beat", {o_last, o_data}, 9'h1ff);
                else chk("payload_beat", {o_last, o_data}, sb.pop_front());
            end
        end
    end

    task automatic build_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                               input logic tag, input logic [15:0] tci, input logic [15:0] ity,
                               input int len, input logic [7:0] seed);
        logic [15:0] ft;
        logic        ok;
        frame_q.delete();
        for (int i = 0; i < 6; i++) frame_q.push_back(8'(dst >> (40 - 8 * i)));
        for (int i = 0; i < 6; i++) frame_q.push_back(8'(src >> (40 - 8 * i)));
        frame_q.push_back(et[15:8]);
        frame_q.push_back(et[7:0]);
        if (tag) begin
            frame_q.push_back(tci[15:8]);
            frame_q.push_back(tci[7:0]);
            frame_q.push_back(ity[15:8]);
            frame_q.push_back(ity[7:0]);
        end
        hdr_len = frame_q.size();
        for (int i = 0; i < len; i++) frame_q.push_back(8'(int'(seed) + i));
        ft = tag ? ity : et;
        ok = (!mac_en || dst == mac_addr || dst == 48'hffff_ffff_ffff) && (!type_en || ft == ethertype);
        if (ok) begin
            for (int i = 0; i < len; i++) sb.push_back({1'(i == len - 1), frame_q[hdr_len + i]});
            exp_dst  = dst;
            exp_src  = src;
            exp_type = ft;
            exp_vlan = tag;
            exp_tci  = tag ? tci : 16'h0;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        logic rdy;
        int   n = 0;
        rx_valid = 1'b1;
        rx_data  = d;
        rx_last  = l;
        do begin
            @(negedge clk);
            rdy = o_tready;
            step();
            n++;
        end while (!rdy && n < 100);
        if (!rdy) chk("rx_accept", rdy, 1);
    endtask

    task automatic send_all(input logic slow);
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i], 1'(i == frame_q.size() - 1));
            if (slow && i >= hdr_len) begin
                rx_valid = 1'b0;
                @(negedge clk);
                chk("lat_valid", o_valid, 1);
                chk("lat_beat", {o_last, o_data}, {1'(i == frame_q.size() - 1), frame_q[i]});
                chk("lat_hdr_valid", o_hdrv, 1);
                step();
            end
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || o_valid) && n < 300) begin
            step();
            n++;
        end
        chk("drain_done", {31'(sb.size()), o_valid}, 0);
    endtask

    task automatic check_hdr(input string tag);
        chk({tag, "_dst"}, o_dst, exp_dst);
        chk({tag, "_src"}, o_src, exp_src);
        chk({tag, "_type"}, o_type, exp_type);
        chk({tag, "_vlan"}, o_vlan, exp_vlan);
        chk({tag, "_tci"}, o_tci, exp_tci);
    endtask

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_last = 1'b0; rx_data = 8'h0; tx_ready = 1'b1;
        mac_en = 1'b0; type_en = 1'b0; mac_addr = 48'h0200_0000_0001; ethertype = 16'h0806;
        exp_dst = '0; exp_src = '0; exp_type = '0; exp_vlan = 1'b0; exp_tci = '0;
        held = 1'b0; held_beat = '0;
        #1;
        chk("rst_tready", o_tready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_hdrv", o_hdrv, 0);
        chk("rst_pulses", {o_drop, o_runt}, 0);
        check_hdr("rst");
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Untagged frame, filters off, one-cycle latency per payload byte
        build_frame(48'h0200_0000_0001, 48'h0200_0000_00aa, 16'h0800, 1'b0, 16'h0, 16'h0, 4, 8'h01);
        send_all(1'b1);
        step();
        @(negedge clk);
        chk("t1_hdrv_clear", o_hdrv, 0);
        chk("t1_valid_clear", o_valid, 0);
        step();
        check_hdr("t1");

        // MAC filter: foreign drops, broadcast and own MAC pass (back to back)
        mac_en = 1'b1;
        build_frame(48'h0200_0000_0002, 48'h0200_0000_00bb, 16'h0800, 1'b0, 16'h0, 16'h0, 5, 8'h10);
        send_all(1'b0);
        drain();
        repeat (2) step();
        chk("t2_drop_cnt", drop_cnt, 1);
        chk("t2_hdrv_after_drop", o_hdrv, 0);
        check_hdr("t2_unchanged");
        build_frame(48'hffff_ffff_ffff, 48'h0200_0000_00cc, 16'h0800, 1'b0, 16'h0, 16'h0, 3, 8'h20);
        send_all(1'b0);
        build_frame(48'h0200_0000_0001, 48'h0200_0000_00dd, 16'h0806, 1'b0, 16'h0, 16'h0, 6, 8'h30);
        send_all(1'b0);
        drain();
        check_hdr("t2_own");
        chk("t2_drop_cnt_final", drop_cnt, 1);
        mac_en = 1'b0;

        // Tagged frame
        build_frame(48'h0200_0000_0003, 48'h0200_0000_00ee, 16'h8100, 1'b1, 16'h6005, 16'h0806, 2, 8'haa);
        send_all(1'b0);
        drain();
        check_hdr("t3_vlan");

        // EtherType filter sees the inner type of a tagged frame
        type_en = 1'b1;
        build_frame(48'h0200_0000_0004, 48'h0200_0000_0011, 16'h0800, 1'b0, 16'h0, 16'h0, 4, 8'h40);
        send_all(1'b0);
        build_frame(48'h0200_0000_0005, 48'h0200_0000_0022, 16'h8100, 1'b1, 16'h0123, 16'h0806, 3, 8'h50);
        send_all(1'b0);
        drain();
        chk("t3b_drop_cnt", drop_cnt, 2);
        check_hdr("t3b_inner");
        type_en = 1'b0;

        // Downstream backpressure mid-payload
        fork
            begin
                build_frame(48'h0200_0000_0006, 48'h0200_0000_0033, 16'h0800, 1'b0, 16'h0, 16'h0, 16, 8'h60);
                send_all(1'b0);
            end
            begin
                repeat (20) step();
                tx_ready = 1'b0;
                @(negedge clk);
                chk("bp_tready_low", o_tready, 0);
                chk("bp_valid_held", o_valid, 1);
                repeat (3) step();
                tx_ready = 1'b1;
            end
        join
        drain();
        check_hdr("t4");

        // Runt: TLAST on the 10th header byte, then a normal frame
        for (int i = 0; i < 10; i++) send_byte(8'(8'h70 + i), 1'(i == 9));
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        repeat (2) step();
        chk("t5_runt_cnt", runt_cnt, 1);
        chk("t5_drop_cnt", drop_cnt, 2);
        chk("t5_hdrv", o_hdrv, 0);
        check_hdr("t5_unchanged");
        build_frame(48'h0200_0000_0007, 48'h0200_0000_0044, 16'h86dd, 1'b0, 16'h0, 16'h0, 5, 8'h80);
        send_all(1'b0);
        drain();
        check_hdr("t5_after");
        chk("t5_runt_cnt_final", runt_cnt, 1);

        // Asynchronous reset in the middle of a payload
        build_frame(48'h0200_0000_0008, 48'h0200_0000_0055, 16'h0800, 1'b0, 16'h0, 16'h0, 8, 8'h90);
        for (int i = 0; i < hdr_len + 3; i++) send_byte(frame_q[i], 1'b0);
        #2;
        rst_n = 1'b0;
        rx_valid = 1'b0;
        #1;
        chk("t6_valid", o_valid, 0);
        chk("t6_beat", {o_last, o_data}, 0);
        chk("t6_hdrv", o_hdrv, 0);
        chk("t6_tready", o_tready, 1);
        sb.delete();
        exp_dst = '0; exp_src = '0; exp_type = '0; exp_vlan = 1'b0; exp_tci = '0;
        check_hdr("t6_rst");
        repeat (2) step();
        rst_n = 1'b1;
        step();
        build_frame(48'h0200_0000_0009, 48'h0200_0000_0066, 16'h0806, 1'b0, 16'h0, 16'h0, 3, 8'ha0);
        send_all(1'b0);
        drain();
        check_hdr("t6_after");
        chk("sb_empty_end", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
